// File: rtl/cfc_ckpt_restore.sv
// Checkpoint restore read engine: sweeps one checkpoint out of the CFC BRAM and
// streams {reg, tag} pairs to the RAT write port through a 2-entry skid FIFO.
module cfc_ckpt_restore #(
  parameter int CKPT_NUM   = 8,
  parameter int ARCH_REGS  = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int ADDR_WIDTH = $clog2(CKPT_NUM * ARCH_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         restore_req,
  input  logic [$clog2(CKPT_NUM)-1:0]  restore_ckpt,
  input  logic                         abort,
  output logic                         restore_busy,
  output logic                         restore_done,
  output logic [ADDR_WIDTH-1:0]        bram_addrb,
  input  logic [TAG_WIDTH-1:0]         bram_doutb,
  output logic                         rat_we,
  output logic [$clog2(ARCH_REGS)-1:0] rat_waddr,
  output logic [TAG_WIDTH-1:0]         rat_wdata,
  input  logic                         rat_rdy
);

  localparam int CKW  = $clog2(CKPT_NUM);
  localparam int IDXW = $clog2(ARCH_REGS);
  localparam int EW   = IDXW + TAG_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [CKW-1:0]        ckpt_q;
  logic [IDXW-1:0]       idx_q;
  logic                  inflight_q;
  logic [IDXW-1:0]       inflight_idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [EW-1:0]         fifo_q [0:1];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [1:0]            count_d;
  logic [EW-1:0]         head;

  assign push    = inflight_q;
  assign rat_we  = (count_q != 2'd0);
  assign pop     = rat_we && rat_rdy;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};
  assign head    = fifo_q[rd_ptr_q];

  // Only issue when the read landing next cycle is guaranteed a FIFO slot.
  assign issue = (state_q == READ) && !abort &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign addr_d = ADDR_WIDTH'(ckpt_q) * ADDR_WIDTH'(ARCH_REGS) + ADDR_WIDTH'(idx_q);

  assign bram_addrb   = issue ? addr_d : addr_q;
  assign restore_busy = (state_q == READ) || (state_q == DRAIN);
  assign restore_done = (state_q == DONE);
  assign rat_waddr    = rat_we ? head[EW-1:TAG_WIDTH] : '0;
  assign rat_wdata    = rat_we ? head[TAG_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ckpt_q         <= '0;
      idx_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      addr_q         <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
    end else if (abort) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_idx_q, bram_doutb};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_idx_q <= idx_q;
      end

      case (state_q)
        IDLE: begin
          if (restore_req) begin
            ckpt_q  <= restore_ckpt;
            idx_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= addr_d;
            idx_q  <= idx_q + IDXW'(1);
            if (idx_q == IDXW'(ARCH_REGS - 1)) begin
              state_q <= DRAIN;
            end
          end
        end
        // Leave one cycle early so DONE coincides with the first empty cycle.
        DRAIN: begin
          if (!inflight_q && count_d == 2'd0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!abort && push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_cfc_ckpt_restore.sv
// Randomised scoreboard bench for cfc_ckpt_restore with a behavioural BRAM and
// an expected-write queue filled from the checkpoint contents at request time.
module tb_cfc_ckpt_restore;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restore_req;
  logic [2:0] restore_ckpt;
  logic       abort;
  logic       restore_busy;
  logic       restore_done;
  logic [7:0] bram_addrb;
  logic [5:0] bram_doutb;
  logic       rat_we;
  logic [4:0] rat_waddr;
  logic [5:0] rat_wdata;
  logic       rat_rdy;

  cfc_ckpt_restore dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restore_req  (restore_req),
    .restore_ckpt (restore_ckpt),
    .abort        (abort),
    .restore_busy (restore_busy),
    .restore_done (restore_done),
    .bram_addrb   (bram_addrb),
    .bram_doutb   (bram_doutb),
    .rat_we       (rat_we),
    .rat_waddr    (rat_waddr),
    .rat_wdata    (rat_wdata),
    .rat_rdy      (rat_rdy)
  );

  always #5 clk = ~clk;

  logic [5:0] mem [0:255];
  always @(posedge clk) bram_doutb <= mem[bram_addrb];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [10:0] exp_q [$];
  int wcount, first_w, last_w, done_cnt, done_cyc;
  bit exempt = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard on each accepted RAT write.
  bit          prev_stall = 1'b0;
  logic [10:0] prev_word;
  logic [10:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !exempt) begin
        check("hold_we", int'(rat_we), 1);
        check("hold_word", int'({rat_waddr, rat_wdata}), int'(prev_word));
      end
      if (rat_we && rat_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'({rat_waddr, rat_wdata}), -1);
        end else begin
          e = exp_q.pop_front();
          check("rat_write", int'({rat_waddr, rat_wdata}), int'(e));
          $display("write reg=%0d tag=%0d cycle=%0d", rat_waddr, rat_wdata, cyc);
          wcount++;
          if (first_w < 0) first_w = cyc;
          last_w = cyc;
        end
      end
      prev_stall = rat_we && !rat_rdy;
      prev_word  = {rat_waddr, rat_wdata};
      if (restore_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_restore(input int ck, output int r);
    restore_req  = 1'b1;
    restore_ckpt = 3'(ck);
    r = cyc;
    wcount = 0; first_w = -1; last_w = -1;
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), mem[ck * 32 + i]});
    $display("restore req ckpt=%0d cycle=%0d", ck, r);
    step();
    restore_req = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (restore_done) begin ok = 1'b1; break; end
      step();
      if (rnd) rat_rdy = 1'($urandom % 2);
    end
    rat_rdy = 1'b1;
    check("done_seen", int'(ok), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic post_checks(input int d0);
    check("write_count", wcount, 32);
    check("queue_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt - d0, 1);
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(restore_busy), 0);
    check({tag, "_done"}, int'(restore_done), 0);
    check({tag, "_we"}, int'(rat_we), 0);
    check({tag, "_waddr"}, int'(rat_waddr), 0);
    check({tag, "_wdata"}, int'(rat_wdata), 0);
    check({tag, "_addr"}, int'(bram_addrb), 0);
  endtask

  initial begin
    int r, r2, d0, busy_err, a5, addr_err;
    rst_n = 1'b0; restore_req = 1'b0; restore_ckpt = '0; abort = 1'b0; rat_rdy = 1'b1;
    done_cnt = 0; done_cyc = -1; wcount = 0; first_w = -1; last_w = -1;
    for (int i = 0; i < 256; i++) mem[i] = 6'($urandom % 64);
    for (int i = 0; i < 32; i++) begin
      mem[i]       = 6'(i);
      mem[160 + i] = 6'(63 - i);
    end
    repeat (3) step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Identity checkpoint, RAT always ready: exact cycle timing.
    d0 = done_cnt;
    start_restore(0, r);
    busy_err = 0;
    for (int k = 0; k < 60; k++) begin
      if (restore_busy != (cyc >= r + 1 && cyc <= r + 34)) busy_err++;
      if (restore_done) break;
      step();
    end
    check("busy_window_errors", busy_err, 0);
    wait_done(10, 1'b0);
    check("first_write_cycle", first_w - r, 3);
    check("last_write_cycle", last_w - r, 34);
    check("done_cycle", done_cyc - r, 35);
    post_checks(d0);

    // Checkpoint 5 with random back-pressure.
    d0 = done_cnt;
    start_restore(5, r);
    wait_done(1000, 1'b1);
    post_checks(d0);

    // Ten-cycle stall starting at cycle 4.
    d0 = done_cnt;
    start_restore(3, r);
    while (cyc < r + 4) step();
    rat_rdy = 1'b0;
    step();
    a5 = int'(bram_addrb);
    addr_err = 0;
    while (cyc < r + 13) begin
      step();
      if (int'(bram_addrb) != a5) addr_err++;
    end
    check("stall_addr_stable_errors", addr_err, 0);
    check("stall_head_idx", int'(rat_waddr), 1);
    step();
    rat_rdy = 1'b1;
    wait_done(100, 1'b0);
    check("stall_last_write_cycle", last_w - r, 44);
    check("stall_done_cycle", done_cyc - r, 45);
    post_checks(d0);

    // Abort at cycle 12, then a fresh restore of checkpoint 7.
    start_restore(2, r);
    while (cyc < r + 12) step();
    abort = 1'b1;
    exempt = 1'b1;
    step();
    abort = 1'b0;
    check("abort_we", int'(rat_we), 0);
    check("abort_busy", int'(restore_busy), 0);
    exp_q.delete();
    d0 = done_cnt;
    step();
    exempt = 1'b0;
    start_restore(7, r2);
    wait_done(100, 1'b0);
    post_checks(d0);

    // Request during an active restore is ignored.
    d0 = done_cnt;
    start_restore(1, r);
    while (cyc < r + 20) step();
    restore_req = 1'b1;
    restore_ckpt = 3'd6;
    step();
    restore_req = 1'b0;
    wait_done(100, 1'b0);
    repeat (50) step();
    check("ignored_req_busy", int'(restore_busy), 0);
    post_checks(d0);

    // Asynchronous reset mid-restore, then a clean restore.
    start_restore(4, r);
    while (cyc < r + 10) step();
    rst_n = 1'b0;
    exempt = 1'b1;
    #1;
    check_zero_outputs("midreset");
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    exempt = 1'b0;
    d0 = done_cnt;
    start_restore(6, r);
    wait_done(100, 1'b1);
    post_checks(d0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
